// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handshake bundle: one instruction per ms_valid & ws_allowin.
interface wb_stage_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW_REG = 5
);
  logic              ms_valid;
  logic              ws_allowin;
  logic [2:0]        ms_op;
  logic [1:0]        ms_addr_lo;
  logic              ms_gr_we;
  logic [AW_REG-1:0] ms_dest;
  logic [DW-1:0]     ms_result;
  logic [DW-1:0]     ms_pc;

  modport master (
    output ms_valid, ms_op, ms_addr_lo, ms_gr_we, ms_dest, ms_result, ms_pc,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_op, ms_addr_lo, ms_gr_we, ms_dest, ms_result, ms_pc,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: holds one instruction, waits for load data, aligns it
// (including LWL/LWR merges) and drives the byte-lane register-file write port.
// Optional macro DEBUG_TRACE_EN adds debug_wb_* trace outputs and registers the PC.
module wb_stage #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW_REG = 5
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         ms,
  input  logic              flush,
  input  logic              dm_rvalid,
  input  logic [DW-1:0]     dm_rdata,
  output logic [3:0]        reg_we,
  output logic [AW_REG-1:0] WR,
  output logic [DW-1:0]     WD,
  output logic              ws_fwd_valid,
  output logic [AW_REG-1:0] ws_fwd_dest,
  output logic              ws_fwd_ready
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_LWL = 3'b110;
  localparam logic [2:0] OP_LWR = 3'b111;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic [2:0]        op_q;
  logic [1:0]        addr_q;
  logic              gr_we_q;
  logic [AW_REG-1:0] dest_q;
  logic [DW-1:0]     wd_q;
  logic [DW-1:0]     load_data;
  logic [DW-1:0]     shr;
  logic [DW-1:0]     shl;
  logic [15:0]       half;
  logic [3:0]        lane_we;
  logic              writes_gpr;

  // acceptance depends only on state, so it is safe to use in next-state logic
  assign xfer       = ms.ms_valid && (state != S_WAIT);
  assign writes_gpr = gr_we_q && (dest_q != '0);
  assign WR          = dest_q;
  assign WD          = wd_q;
  assign ws_fwd_dest = dest_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // next-state: loads park in WAIT until data or flush; ALU ops go straight to READY
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY, S_READY: begin
        if (xfer) state_nxt = (ms.ms_op == OP_ALU) ? S_READY : S_WAIT;
        else      state_nxt = S_EMPTY;
      end
      S_WAIT: begin
        if (flush)          state_nxt = S_EMPTY;
        else if (dm_rvalid) state_nxt = S_READY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // outputs decoded from state and the held entry
  always_comb begin
    ms.ws_allowin = 1'b0;
    reg_we        = 4'b0000;
    ws_fwd_valid  = 1'b0;
    ws_fwd_ready  = 1'b0;
    case (state)
      S_EMPTY: ms.ws_allowin = 1'b1;
      S_WAIT:  ws_fwd_valid  = writes_gpr;
      S_READY: begin
        ms.ws_allowin = 1'b1;
        ws_fwd_ready  = 1'b1;
        ws_fwd_valid  = writes_gpr;
        if (writes_gpr) reg_we = lane_we;
      end
      default: ;
    endcase
  end

  // held instruction entry and write data
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_ALU;
      addr_q  <= 2'b00;
      gr_we_q <= 1'b0;
      dest_q  <= '0;
      wd_q    <= '0;
    end else if (xfer) begin
      op_q    <= ms.ms_op;
      addr_q  <= ms.ms_addr_lo;
      gr_we_q <= ms.ms_gr_we;
      dest_q  <= ms.ms_dest;
      if (ms.ms_op == OP_ALU) wd_q <= ms.ms_result;
    end else if ((state == S_WAIT) && dm_rvalid && !flush) begin
      wd_q <= load_data;
    end
  end

  // load alignment; LWL/LWR shifts leave the unwritten lanes zero
  always_comb begin
    shr  = dm_rdata >> {addr_q, 3'b000};
    shl  = dm_rdata << {2'(2'd3 - addr_q), 3'b000};
    half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{shr[7]}}, shr[7:0]};
      OP_LBU:  load_data = {24'h000000, shr[7:0]};
      OP_LH:   load_data = {{16{half[15]}}, half};
      OP_LHU:  load_data = {16'h0000, half};
      OP_LWL:  load_data = shl;
      OP_LWR:  load_data = shr;
      default: load_data = dm_rdata;
    endcase
  end

  // byte-lane enables for partial-word merges
  always_comb begin
    case (op_q)
      OP_LWL:  lane_we = 4'b1111 << (2'd3 - addr_q);
      OP_LWR:  lane_we = 4'b1111 >> addr_q;
      default: lane_we = 4'b1111;
    endcase
  end

`ifdef DEBUG_TRACE_EN
  logic [31:0] pc_q;

  // PC travels with the entry for the commit trace
  always_ff @(posedge clk) begin
    if (rst)       pc_q <= '0;
    else if (xfer) pc_q <= 32'(ms.ms_pc);
  end

  // trace mirrors the write port only while committing
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (state == S_READY) begin
      debug_wb_pc       = pc_q;
      debug_wb_rf_we    = reg_we;
      debug_wb_rf_wnum  = 5'(dest_q);
      debug_wb_rf_wdata = 32'(wd_q);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^ms.ms_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for load alignment plus hand sequences.
module tb_wb_stage;

  localparam logic [2:0] ALU = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LBU = 3'b010;
  localparam logic [2:0] LH  = 3'b011;
  localparam logic [2:0] LHU = 3'b100;
  localparam logic [2:0] LW  = 3'b101;
  localparam logic [2:0] LWL = 3'b110;
  localparam logic [2:0] LWR = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [3:0]  reg_we;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic        ws_fwd_ready;
`ifdef DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int errors = 0;
  int checks = 0;

  wb_stage_if bus ();

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ms           (bus.slave),
    .flush        (flush),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .reg_we       (reg_we),
    .WR           (WR),
    .WD           (WD),
    .ws_fwd_valid (ws_fwd_valid),
    .ws_fwd_dest  (ws_fwd_dest),
    .ws_fwd_ready (ws_fwd_ready)
`ifdef DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] m;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        chk_wd;
  } vec_t;

  vec_t vt[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [1:0] a, input logic gr_we,
                         input logic [4:0] dest, input logic [31:0] res);
    bus.ms_valid   = 1'b1;
    bus.ms_op      = op;
    bus.ms_addr_lo = a;
    bus.ms_gr_we   = gr_we;
    bus.ms_dest    = dest;
    bus.ms_result  = res;
    bus.ms_pc      = 32'hBFC0_0000 | {27'd0, dest};
  endtask

  initial begin
    vt[0]  = '{ALU, 2'd0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b1};
    vt[1]  = '{ALU, 2'd0, 1'b1, 5'd0,  32'h12345678, 32'h0,        4'b0000, 32'h0,        1'b0};
    vt[2]  = '{ALU, 2'd0, 1'b0, 5'd7,  32'h12345678, 32'h0,        4'b0000, 32'h0,        1'b0};
    vt[3]  = '{LB,  2'd3, 1'b1, 5'd10, 32'h0,        32'h80FF7F01, 4'b1111, 32'hFFFFFF80, 1'b1};
    vt[4]  = '{LB,  2'd0, 1'b1, 5'd11, 32'h0,        32'h80FF7F01, 4'b1111, 32'h00000001, 1'b1};
    vt[5]  = '{LB,  2'd1, 1'b1, 5'd12, 32'h0,        32'h80FF7F01, 4'b1111, 32'h0000007F, 1'b1};
    vt[6]  = '{LBU, 2'd3, 1'b1, 5'd13, 32'h0,        32'h80FF7F01, 4'b1111, 32'h00000080, 1'b1};
    vt[7]  = '{LBU, 2'd2, 1'b1, 5'd14, 32'h0,        32'h80FF7F01, 4'b1111, 32'h000000FF, 1'b1};
    vt[8]  = '{LHU, 2'd2, 1'b1, 5'd15, 32'h0,        32'h80FF7F01, 4'b1111, 32'h000080FF, 1'b1};
    vt[9]  = '{LH,  2'd2, 1'b1, 5'd16, 32'h0,        32'h80FF7F01, 4'b1111, 32'hFFFF80FF, 1'b1};
    vt[10] = '{LH,  2'd1, 1'b1, 5'd17, 32'h0,        32'h80FF7F01, 4'b1111, 32'h00007F01, 1'b1};
    vt[11] = '{LW,  2'd2, 1'b1, 5'd18, 32'h0,        32'h44332211, 4'b1111, 32'h44332211, 1'b1};
    vt[12] = '{LWL, 2'd0, 1'b1, 5'd19, 32'h0,        32'h44332211, 4'b1000, 32'h11000000, 1'b1};
    vt[13] = '{LWL, 2'd1, 1'b1, 5'd20, 32'h0,        32'h44332211, 4'b1100, 32'h22110000, 1'b1};
    vt[14] = '{LWL, 2'd3, 1'b1, 5'd21, 32'h0,        32'h44332211, 4'b1111, 32'h44332211, 1'b1};
    vt[15] = '{LWR, 2'd0, 1'b1, 5'd22, 32'h0,        32'h44332211, 4'b1111, 32'h44332211, 1'b1};
    vt[16] = '{LWR, 2'd2, 1'b1, 5'd23, 32'h0,        32'h44332211, 4'b0011, 32'h00004433, 1'b1};
    vt[17] = '{LWR, 2'd3, 1'b1, 5'd24, 32'h0,        32'h44332211, 4'b0001, 32'h00000044, 1'b1};
    vt[18] = '{LWL, 2'd2, 1'b1, 5'd25, 32'h0,        32'h44332211, 4'b1110, 32'h33221100, 1'b1};

    // reset held with a valid instruction offered: nothing may be taken or written
    rst = 1'b1; flush = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    present(ALU, 2'd0, 1'b1, 5'd3, 32'h55555555);
    step(); step();
    chk("rst_reg_we", 32'(reg_we), 32'h0);
    chk("rst_allowin", 32'(bus.ws_allowin), 32'h1);
    chk("rst_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    chk("rst_WR", 32'(WR), 32'h0);
    chk("rst_WD", WD, 32'h0);
    bus.ms_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_reg_we", 32'(reg_we), 32'h0);

    // ALU streaming, one commit per cycle
    present(ALU, 2'd0, 1'b1, 5'd1, 32'h11111111);
    step();
    chk("s1_we", 32'(reg_we), 32'hF);
    chk("s1_WR", 32'(WR), 32'd1);
    chk("s1_WD", WD, 32'h11111111);
    chk("s1_fwd_ready", 32'(ws_fwd_ready), 32'h1);
    present(ALU, 2'd0, 1'b1, 5'd2, 32'h22222222);
    step();
    chk("s2_we", 32'(reg_we), 32'hF);
    chk("s2_WR", 32'(WR), 32'd2);
    chk("s2_WD", WD, 32'h22222222);
    present(ALU, 2'd0, 1'b1, 5'd3, 32'h33333333);
    step();
    chk("s3_we", 32'(reg_we), 32'hF);
    chk("s3_WR", 32'(WR), 32'd3);
    chk("s3_WD", WD, 32'h33333333);
    chk("s3_fwd_dest", 32'(ws_fwd_dest), 32'd3);
    present(ALU, 2'd0, 1'b1, 5'd0, 32'h44444444);
    step();
    chk("s4_dest0_we", 32'(reg_we), 32'h0);
    chk("s4_dest0_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    bus.ms_valid = 1'b0;
    step();
    chk("s5_empty_we", 32'(reg_we), 32'h0);
    chk("s5_empty_allowin", 32'(bus.ws_allowin), 32'h1);

    // table of single instructions, each drained back to empty
    for (int i = 0; i < 19; i++) begin
      present(vt[i].op, vt[i].a, vt[i].gr_we, vt[i].dest, vt[i].res);
      dm_rdata = vt[i].m;
      step();
      bus.ms_valid = 1'b0;
      if (vt[i].op != ALU) begin
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
      end
      chk($sformatf("v%0d_we", i), 32'(reg_we), 32'(vt[i].we));
      chk($sformatf("v%0d_WR", i), 32'(WR), 32'(vt[i].dest));
      if (vt[i].chk_wd) chk($sformatf("v%0d_WD", i), WD, vt[i].wd);
      step();
      chk($sformatf("v%0d_drain_we", i), 32'(reg_we), 32'h0);
    end

    // load stall; rvalid in the acceptance cycle must be ignored
    present(LW, 2'd0, 1'b1, 5'd9, 32'h0);
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
    step();
    dm_rvalid = 1'b0;
    present(ALU, 2'd0, 1'b1, 5'd30, 32'h77777777);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_allowin", c), 32'(bus.ws_allowin), 32'h0);
      chk($sformatf("stall%0d_fwd_valid", c), 32'(ws_fwd_valid), 32'h1);
      chk($sformatf("stall%0d_fwd_ready", c), 32'(ws_fwd_ready), 32'h0);
      chk($sformatf("stall%0d_fwd_dest", c), 32'(ws_fwd_dest), 32'd9);
      chk($sformatf("stall%0d_we", c), 32'(reg_we), 32'h0);
      step();
    end
    bus.ms_valid = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D;
    step();
    dm_rvalid = 1'b0;
    chk("stall_commit_we", 32'(reg_we), 32'hF);
    chk("stall_commit_WR", 32'(WR), 32'd9);
    chk("stall_commit_WD", WD, 32'hCAFEF00D);
    step();
    chk("stall_drain_we", 32'(reg_we), 32'h0);

    // flush in WAIT discards the load even with data arriving
    present(LW, 2'd0, 1'b1, 5'd4, 32'h0);
    step();
    bus.ms_valid = 1'b0;
    flush = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h0BADF00D;
    step();
    flush = 1'b0; dm_rvalid = 1'b0;
    chk("flush_wait_we", 32'(reg_we), 32'h0);
    chk("flush_wait_allowin", 32'(bus.ws_allowin), 32'h1);
    chk("flush_wait_fwd_valid", 32'(ws_fwd_valid), 32'h0);
    present(ALU, 2'd0, 1'b1, 5'd6, 32'h66666666);
    step();
    // flush in READY: commit still happens and a new load is still accepted
    flush = 1'b1;
    present(LW, 2'd0, 1'b1, 5'd8, 32'h0);
    chk("flush_ready_we", 32'(reg_we), 32'hF);
    chk("flush_ready_WR", 32'(WR), 32'd6);
    chk("flush_ready_WD", WD, 32'h66666666);
    step();
    flush = 1'b0;
    bus.ms_valid = 1'b0;
    chk("flush_ready_next_allowin", 32'(bus.ws_allowin), 32'h0);
    chk("flush_ready_next_fwd_dest", 32'(ws_fwd_dest), 32'd8);
    dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
    step();
    dm_rvalid = 1'b0;
    chk("flush_ready_load_we", 32'(reg_we), 32'hF);
    chk("flush_ready_load_WD", WD, 32'h12345678);
    step();
    chk("final_empty_we", 32'(reg_we), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
